// File: rtl/beat_seq_pkg.sv
// Shared types and constants for the step sequencer pattern player.
// Optional macro BEAT_SEQ_PRESET_PATTERN_EN selects DEFAULT_PATTERN as the reset pattern.
package beat_seq_pkg;

  localparam int unsigned STEP_W     = 4;
  localparam int unsigned NUM_STEPS  = 1 << STEP_W;
  localparam int unsigned NUM_TRACKS = 4;
  localparam int unsigned TRACK_W    = 2;

  typedef logic [STEP_W-1:0]                 step_idx_t;
  typedef logic [TRACK_W-1:0]                track_idx_t;
  typedef logic [NUM_STEPS-1:0]              pattern_row_t;
  typedef pattern_row_t [NUM_TRACKS-1:0]     pattern_t;

  typedef enum logic {
    STOPPED = 1'b0,
    PLAYING = 1'b1
  } play_state_t;

  // Row 0 is the least significant 16 bits: track0 {0,8}, track1 {4,12}, track2 even, track3 off.
  localparam pattern_t DEFAULT_PATTERN = {16'h0000, 16'h5555, 16'h1010, 16'h0101};

endpackage

// File: rtl/step_pattern_player_if.sv
// Step bus, edit port and LED taps of the pattern player.
// master: sequencer/debouncer side; slave: the player itself.
interface step_pattern_player_if;
  import beat_seq_pkg::*;

  logic                  run;
  step_idx_t             step;
  logic [NUM_TRACKS-1:0] mute;
  track_idx_t            edit_track;
  step_idx_t             edit_step;
  logic                  edit_toggle;
  logic [NUM_TRACKS-1:0] trig;
  logic                  step_strobe;
  step_idx_t             cur_step;
  logic [NUM_TRACKS-1:0] step_column;
  pattern_row_t          edit_row;

  modport master (
    output run, step, mute, edit_track, edit_step, edit_toggle,
    input  trig, step_strobe, cur_step, step_column, edit_row
  );

  modport slave (
    input  run, step, mute, edit_track, edit_step, edit_toggle,
    output trig, step_strobe, cur_step, step_column, edit_row
  );

endinterface

// File: rtl/trig_pulse_gen.sv
// Fixed-width trigger pulse; a fire while the pulse is high restarts the full width.
module trig_pulse_gen #(
  parameter int unsigned TRIG_CYCLES = 250000,
  parameter int unsigned TRIG_CNT_W  = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  output logic pulse
);

  logic [TRIG_CNT_W-1:0] r_cnt;

  // Load on fire, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (fire) begin
      r_cnt <= TRIG_CNT_W'(TRIG_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign pulse = (r_cnt != '0);

endmodule

// File: rtl/step_pattern_player.sv
// Plays a NUM_TRACKS x NUM_STEPS on/off pattern against the incoming step index.
// Optional macro BEAT_SEQ_PRESET_PATTERN_EN: reset loads DEFAULT_PATTERN instead of zeros.
module step_pattern_player import beat_seq_pkg::*; #(
  parameter int unsigned TRIG_CYCLES = 250000,
  parameter int unsigned TRIG_CNT_W  = 18
) (
  input logic                   clk,
  input logic                   reset,
  step_pattern_player_if.slave  bus
);

`ifdef BEAT_SEQ_PRESET_PATTERN_EN
  localparam pattern_t RESET_PATTERN = DEFAULT_PATTERN;
`else
  localparam pattern_t RESET_PATTERN = '0;
`endif

  play_state_t           r_state;
  play_state_t           w_state_next;
  pattern_t              r_pattern;
  step_idx_t             r_prev_step;
  step_idx_t             r_cur_step;
  logic                  r_strobe;
  logic                  w_fire;
  logic                  w_edit_ok;
  logic [NUM_TRACKS-1:0] w_fire_trk;
  logic [NUM_TRACKS-1:0] w_trig;
  logic [NUM_TRACKS-1:0] w_step_column;

  // Play FSM: starting playback fires the current step; while playing, any step change fires.
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    case (r_state)
      STOPPED: begin
        if (bus.run) begin
          w_state_next = PLAYING;
          w_fire       = 1'b1;
        end
      end
      PLAYING: begin
        if (!bus.run) begin
          w_state_next = STOPPED;
        end else if (bus.step != r_prev_step) begin
          w_fire = 1'b1;
        end
      end
      default: w_state_next = STOPPED;
    endcase
  end

  // Per-track fire: active cell at the sampled step, track not muted (pre-toggle pattern).
  always_comb begin
    w_fire_trk = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      w_fire_trk[t] = w_fire & r_pattern[t][bus.step] & ~bus.mute[t];
    end
  end

  assign w_edit_ok = (32'(bus.edit_track) < NUM_TRACKS);

  // FSM state, step history and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= STOPPED;
      r_prev_step <= '0;
      r_cur_step  <= '0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev_step <= bus.step;
      r_strobe    <= w_fire;
      if (w_fire) begin
        r_cur_step <= bus.step;
      end
    end
  end

  // Pattern storage with single-cell toggle edits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= RESET_PATTERN;
    end else if (bus.edit_toggle && w_edit_ok) begin
      r_pattern[bus.edit_track][bus.edit_step] <= ~r_pattern[bus.edit_track][bus.edit_step];
    end
  end

  for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_trig
    trig_pulse_gen #(
      .TRIG_CYCLES (TRIG_CYCLES),
      .TRIG_CNT_W  (TRIG_CNT_W)
    ) u_trig_pulse_gen (
      .clk   (clk),
      .reset (reset),
      .fire  (w_fire_trk[g]),
      .pulse (w_trig[g])
    );
  end

  // LED column follows the live pattern at the last played step.
  always_comb begin
    w_step_column = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      w_step_column[t] = r_pattern[t][r_cur_step];
    end
  end

  assign bus.trig        = w_trig;
  assign bus.step_strobe = r_strobe;
  assign bus.cur_step    = r_cur_step;
  assign bus.step_column = w_step_column;
  assign bus.edit_row    = w_edit_ok ? r_pattern[bus.edit_track] : '0;

endmodule

// File: doc/step_pattern_player.md
Name: step_pattern_player

Overview:
- Consumer end of the sequencer step bus. Watches the 4-bit step index from the tempo/step counter and reads a 4-track x 16-step on/off pattern held in registers.
- Emits fixed-width trigger pulses to the voice/sample players for every active, unmuted cell at each new step.
- Also owns the pattern edit port, driven by the key/switch debouncers, and the LED display taps.

Parameters:
- NUM_TRACKS, 4, number of drum tracks (pattern rows)
- NUM_STEPS, 16, steps per bar; must equal 2**STEP_W
- STEP_W, 4, width of step index
- TRIG_CYCLES, 250000, trigger pulse width in clk cycles (5 ms at 50 MHz); must be >= 1
- TRIG_CNT_W, 18, width of pulse counter; must hold TRIG_CYCLES

Ports:
- clk, in, 1, system clock (50 MHz)
- reset, in, 1, synchronous active-high reset
- run, in, 1, playback enable (level)
- step, in, STEP_W, step index from step counter
- mute, in, NUM_TRACKS, per-track mute (level)
- edit_track, in, 2, track selected for edit
- edit_step, in, STEP_W, step selected for edit
- edit_toggle, in, 1, single-cycle pulse; inverts cell [edit_track][edit_step]
- trig, out, NUM_TRACKS, per-track trigger pulses
- step_strobe, out, 1, one-cycle pulse when a step is played
- cur_step, out, STEP_W, last played step
- step_column, out, NUM_TRACKS, pattern bits of all tracks at cur_step (LEDs)
- edit_row, out, NUM_STEPS, full pattern row of edit_track (LEDs)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the clock is clk and the reset is reset.
- Reset:
  - pattern all 0; trig=0; step_strobe=0; cur_step=0; step_column=0; prev_step=0.
  - Play FSM goes to STOPPED; all pulse counters go to 0.
  - Reset asserted mid-pulse drops trig on the next edge.
- Play FSM, two states:
  - STOPPED:
    - No fires.
    - run=1 -> PLAYING, and the current step is fired immediately (FIRE event next cycle), whether or not step changed.
  - PLAYING:
    - FIRE event whenever sampled step != prev_step. This covers wrap 15->0 and non-consecutive jumps.
    - Same step held for any time -> no refire.
    - run=0 -> STOPPED. Pulses already running complete their full width.
- prev_step register:
  - Updates to step every cycle while not in reset, including while STOPPED.
- FIRE timing (change sampled at edge N):
  - At edge N+1: step_strobe=1 for exactly one cycle.
  - cur_step=step value sampled at N.
  - trig[t] rises for every t with pattern[t][step] && !mute[t].
- Trigger channels:
  - trig[t] stays high exactly TRIG_CYCLES cycles.
  - A fire on a channel that is still high reloads the counter; trig stays high with no gap.
  - Mute affects only new fires; it does not truncate a running pulse.
- step_column:
  - Combinational from pattern and cur_step, so it reflects edits immediately.
- edit_row:
  - Combinational, pattern[edit_track].
- edit_toggle:
  - Pattern cell inverted at the next edge.
  - Edit and fire at the same edge on the same cell: trig uses the pre-toggle value; the toggle is visible from the next cycle.
  - Edits are accepted in both FSM states.
- edit_track >= NUM_TRACKS: toggle ignored; edit_row=0.

Optional Feature:
- Macro: BEAT_SEQ_PRESET_PATTERN_EN.
- Defined: reset loads the preset from the package constant DEFAULT_PATTERN instead of all-zero. The preset is:
  - track0 steps 0,8
  - track1 steps 4,12
  - track2 every even step
  - track3 = 0
- Undefined: reset clears the pattern. No other behaviour changes.

Decomposition:
- Package beat_seq_pkg:
  - STEP_W, NUM_STEPS, NUM_TRACKS
  - typedefs step_idx_t, track_idx_t, pattern_row_t (NUM_STEPS bits), pattern_t (NUM_TRACKS rows)
  - play_state_t enum {STOPPED, PLAYING}
  - DEFAULT_PATTERN constant
- Sub-module trig_pulse_gen, instantiated NUM_TRACKS times:
  - Inputs clk, reset, fire; output pulse.
  - Parameters TRIG_CYCLES and TRIG_CNT_W.
  - Implements the load/reload-on-fire countdown.

Test Plan (TRIG_CYCLES=8 in simulation):
1. Reset, toggle cells [0][3] and [2][3], run=1, step 2->3 -> one cycle after the change: step_strobe=1 and cur_step=3; trig=4'b0101 held exactly 8 cycles, then 0.
2. Step 15->0 with [1][0] set -> fire on wrap; trig[1] high 8 cycles. Step held at 0 for 100 cycles -> no second strobe.
3. Refire: [0][4] and [0][5] set; step 4->5 three cycles after the previous fire -> trig[0] stays high continuously, falling 8 cycles after the second fire.
4. mute=4'b0001, [0][6] and [1][6] set, step->6 -> trig=4'b0010. Mute asserted during a running pulse -> pulse still lasts 8 cycles.
5. run 0->1 while step=7 with [3][7] set -> fire one cycle later with no step change. run=0 mid-pulse -> pulse completes; later step changes do not fire.
6. Edit toggle on [2][9] at the same edge as a fire on step 9 (cell initially 0) -> trig[2]=0 this step; edit_row for track 2 shows bit 9 set next cycle. Reset mid-pulse -> trig=0 the next cycle and pattern cleared (or equal to DEFAULT_PATTERN with BEAT_SEQ_PRESET_PATTERN_EN).
